// File: rtl/temp_mode_selector.sv
`timescale 1ns/1ps
// temp_mode_selector
//   Two-button (up/down) selector over NUM_MODES temperature modes. Each raw
//   button is synchronised by two flops and debounced by a per-button counter.
//   A debounced rising edge becomes a one-cycle step event. Steps wrap or
//   saturate depending on WRAP. The mode code, a one-hot indicator and a
//   change pulse are all registered.
//
//   Optional build macro: TEMP_MODE_AUTOREPEAT_EN
//     When defined, holding a single button auto-repeats its step after
//     REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
//
//   Ports:
//     clk           system clock
//     rst           asynchronous reset, active-high
//     btn_up        raw up button (asynchronous, active-high)
//     btn_down      raw down button (asynchronous, active-high)
//     en            when 0, step events are discarded
//     clear         forces the mode to RESET_MODE
//     mode          current mode code
//     led           one-hot of mode (led[mode] = 1)
//     mode_changed  one-cycle pulse in the first cycle mode shows a new value
module temp_mode_selector #(
    parameter int NUM_MODES       = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int WRAP            = 1,
    parameter int RESET_MODE      = 0,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         btn_up,
    input  logic                         btn_down,
    input  logic                         en,
    input  logic                         clear,
    output logic [$clog2(NUM_MODES)-1:0] mode,
    output logic [NUM_MODES-1:0]         led,
    output logic                         mode_changed
);

    localparam int MODE_W = $clog2(NUM_MODES);
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);

    // Reject configurations the datapath cannot represent.
    if (NUM_MODES < 2 || RESET_MODE >= NUM_MODES || DEBOUNCE_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("temp_mode_selector: illegal parameter combination");
    end

    // Button index 0 is up, index 1 is down.
    logic [1:0] btn_raw_s;
    logic [1:0] press_s;
    logic [1:0] step_s;
`ifdef TEMP_MODE_AUTOREPEAT_EN
    logic [1:0] level_s;
`endif

    assign btn_raw_s = {btn_down, btn_up};

    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic             sync1_r;
        logic             sync2_r;
        logic             level_r;
        logic             level_d_r;
        logic             press_r;
        logic [CNT_W-1:0] cnt_r;

        // Two-flop synchroniser: the only consumer of the raw button.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_r <= 1'b0;
                sync2_r <= 1'b0;
            end else begin
                sync1_r <= btn_raw_s[i];
                sync2_r <= sync1_r;
            end
        end

        // Debouncer: level flips only after DEBOUNCE_CYCLES consecutive mismatches.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                level_r <= 1'b0;
                cnt_r   <= {CNT_W{1'b0}};
            end else if (sync2_r != level_r) begin
                if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_r <= ~level_r;
                    cnt_r   <= {CNT_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
        end

        // Rising-edge detector; the event is registered so the mode step
        // lands one edge after the debounced level is seen high.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                level_d_r <= 1'b0;
                press_r   <= 1'b0;
            end else begin
                level_d_r <= level_r;
                press_r   <= level_r & ~level_d_r;
            end
        end

        assign press_s[i] = press_r;
`ifdef TEMP_MODE_AUTOREPEAT_EN
        assign level_s[i] = level_r;
`endif
    end

`ifdef TEMP_MODE_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    for (genvar i = 0; i < 2; i++) begin : g_rep
        logic             holding_s;
        logic [REP_W-1:0] hold_r;
        logic             phase_r;   // 0: waiting for initial delay, 1: periodic
        logic             rep_r;

        // Holding both buttons suppresses repeat entirely.
        assign holding_s = level_s[i] & ~level_s[1-i];

        // Hold counter: first repeat after REPEAT_DELAY held edges, then every REPEAT_PERIOD.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hold_r  <= {REP_W{1'b0}};
                phase_r <= 1'b0;
                rep_r   <= 1'b0;
            end else if (!holding_s) begin
                hold_r  <= {REP_W{1'b0}};
                phase_r <= 1'b0;
                rep_r   <= 1'b0;
            end else if ((!phase_r && hold_r == REP_W'(REPEAT_DELAY - 1)) ||
                         ( phase_r && hold_r == REP_W'(REPEAT_PERIOD - 1))) begin
                hold_r  <= {REP_W{1'b0}};
                phase_r <= 1'b1;
                rep_r   <= 1'b1;
            end else begin
                hold_r  <= hold_r + REP_W'(1);
                rep_r   <= 1'b0;
            end
        end

        assign step_s[i] = press_s[i] | rep_r;
    end
`else
    assign step_s = press_s;
`endif

    logic [MODE_W-1:0]    mode_r;
    logic [NUM_MODES-1:0] led_r;
    logic                 changed_r;
    logic [MODE_W-1:0]    mode_next_s;
    logic                 changed_next_s;
    logic [NUM_MODES-1:0] led_next_s;

    // Mode update with priority clear > enable > simultaneous events > single step.
    always_comb begin
        mode_next_s    = mode_r;
        changed_next_s = 1'b0;
        if (clear) begin
            mode_next_s    = MODE_W'(RESET_MODE);
            changed_next_s = (mode_r != MODE_W'(RESET_MODE));
        end else if (!en) begin
            mode_next_s    = mode_r;
        end else if (step_s[0] && step_s[1]) begin
            mode_next_s    = mode_r;
        end else if (step_s[0]) begin
            if (mode_r == MODE_W'(NUM_MODES - 1)) begin
                if (WRAP != 0) begin
                    mode_next_s    = {MODE_W{1'b0}};
                    changed_next_s = 1'b1;
                end else begin
                    mode_next_s    = mode_r;
                end
            end else begin
                mode_next_s    = mode_r + MODE_W'(1);
                changed_next_s = 1'b1;
            end
        end else if (step_s[1]) begin
            if (mode_r == {MODE_W{1'b0}}) begin
                if (WRAP != 0) begin
                    mode_next_s    = MODE_W'(NUM_MODES - 1);
                    changed_next_s = 1'b1;
                end else begin
                    mode_next_s    = mode_r;
                end
            end else begin
                mode_next_s    = mode_r - MODE_W'(1);
                changed_next_s = 1'b1;
            end
        end else begin
            mode_next_s    = mode_r;
        end
    end

    // One-hot decode of the next mode so led and mode change on the same edge.
    always_comb begin
        led_next_s = {{(NUM_MODES-1){1'b0}}, 1'b1} << mode_next_s;
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r    <= MODE_W'(RESET_MODE);
            led_r     <= {{(NUM_MODES-1){1'b0}}, 1'b1} << RESET_MODE;
            changed_r <= 1'b0;
        end else begin
            mode_r    <= mode_next_s;
            led_r     <= led_next_s;
            changed_r <= changed_next_s;
        end
    end

    assign mode         = mode_r;
    assign led          = led_r;
    assign mode_changed = changed_r;

endmodule

// File: tb/tb_temp_mode_selector.sv
`timescale 1ns/1ps
module tb_temp_mode_selector;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] up_b, dn_b, en_b, clr_b;

    logic [1:0] mode0, mode1, mode2;
    logic [3:0] led0, led1;
    logic [2:0] led2;
    logic ch0, ch1, ch2;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int sb_e;
    int pc1 = 0;
    int pc2 = 0;

    always #5 clk = ~clk;

    // d0: 4 modes, wrap (auto-repeat timing used when the macro is defined)
    temp_mode_selector #(.NUM_MODES(4), .DEBOUNCE_CYCLES(4), .WRAP(1), .RESET_MODE(0),
                         .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) d0 (
        .clk(clk), .rst(rst), .btn_up(up_b[0]), .btn_down(dn_b[0]), .en(en_b[0]),
        .clear(clr_b[0]), .mode(mode0), .led(led0), .mode_changed(ch0));

    // d1: 4 modes, saturate
    temp_mode_selector #(.NUM_MODES(4), .DEBOUNCE_CYCLES(4), .WRAP(0), .RESET_MODE(0),
                         .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) d1 (
        .clk(clk), .rst(rst), .btn_up(up_b[1]), .btn_down(dn_b[1]), .en(en_b[1]),
        .clear(clr_b[1]), .mode(mode1), .led(led1), .mode_changed(ch1));

    // d2: 3 modes, saturate
    temp_mode_selector #(.NUM_MODES(3), .DEBOUNCE_CYCLES(4), .WRAP(0), .RESET_MODE(0),
                         .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) d2 (
        .clk(clk), .rst(rst), .btn_up(up_b[2]), .btn_down(dn_b[2]), .en(en_b[2]),
        .clear(clr_b[2]), .mode(mode2), .led(led2), .mode_changed(ch2));

    // Scoreboard: every d0 change pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && ch0 === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_pulse: mode=%0d led=%b, required no pulse", mode0, led0);
            end else begin
                sb_e = exp_q.pop_front();
                if (mode0 !== 2'(sb_e) || led0 !== (4'b0001 << sb_e)) begin
                    failures++;
                    $display("FAIL sb_pulse: mode=%0d led=%b, required mode=%0d led=%b",
                             mode0, led0, sb_e, 4'b0001 << sb_e);
                end
            end
        end
    end

    // Pulse counters for the saturating instances.
    always @(negedge clk) begin
        if (rst === 1'b0 && ch1 === 1'b1) pc1++;
        if (rst === 1'b0 && ch2 === 1'b1) pc2++;
    end

    task automatic press(input int d, input bit up, input int hold, input int settle);
        @(negedge clk);
        if (up) up_b[d] = 1'b1; else dn_b[d] = 1'b1;
        repeat (hold) @(negedge clk);
        if (up) up_b[d] = 1'b0; else dn_b[d] = 1'b0;
        repeat (settle) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; up_b = 3'b000; dn_b = 3'b000; en_b = 3'b111; clr_b = 3'b000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            checks++;
            if (mode0 !== 2'd0 || led0 !== 4'b0001 || ch0 !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle: cycle %0d mode=%0d led=%b chg=%b, required 0/0001/0",
                         c, mode0, led0, ch0);
            end
        end
    endtask

    task automatic test_up_wrap();
        for (int k = 0; k < 4; k++) begin
            automatic int e = (k + 1) % 4;
            @(negedge clk);
            up_b[0] = 1'b1;
            exp_q.push_back(e);
            repeat (7) @(posedge clk);
            #1;
            checks++;
            if (mode0 !== 2'(k)) begin
                failures++;
                $display("FAIL up_early: press %0d mode=%0d before edge 7, required %0d", k, mode0, k);
            end
            @(posedge clk);
            #1;
            checks++;
            if (mode0 !== 2'(e) || ch0 !== 1'b1) begin
                failures++;
                $display("FAIL up_latency: press %0d mode=%0d chg=%b at edge 7, required %0d/1", k, mode0, ch0, e);
            end
            @(posedge clk);
            #1;
            checks++;
            if (ch0 !== 1'b0) begin
                failures++;
                $display("FAIL up_pulse_width: press %0d chg=%b one cycle later, required 0", k, ch0);
            end
            repeat (2) @(negedge clk);
            up_b[0] = 1'b0;
            repeat (12) @(negedge clk);
        end
    endtask

    task automatic test_glitch();
        press(0, 1'b1, 3, 15);
        for (int b = 0; b < 5; b++) begin
            up_b[0] = 1'b1;
            repeat (2) @(negedge clk);
            up_b[0] = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (15) @(negedge clk);
        checks++;
        if (mode0 !== 2'd0) begin
            failures++;
            $display("FAIL glitch: mode=%0d, required 0", mode0);
        end
    endtask

    task automatic test_saturate();
        press(1, 1'b0, 10, 15);
        checks++;
        if (mode1 !== 2'd0 || pc1 != 0) begin
            failures++;
            $display("FAIL sat_low: mode=%0d pulses=%0d, required 0/0", mode1, pc1);
        end
        for (int k = 0; k < 3; k++) begin
            automatic int e = (k < 2) ? k + 1 : 2;
            press(2, 1'b1, 10, 15);
            checks++;
            if (mode2 !== 2'(e) || led2 !== (3'b001 << e)) begin
                failures++;
                $display("FAIL sat_high: press %0d mode=%0d led=%b, required %0d", k, mode2, led2, e);
            end
        end
        checks++;
        if (pc2 != 2) begin
            failures++;
            $display("FAIL sat_high_pulses: pulses=%0d, required 2", pc2);
        end
    endtask

    task automatic test_both();
        @(negedge clk);
        up_b[0] = 1'b1; dn_b[0] = 1'b1;
        repeat (15) @(negedge clk);
        up_b[0] = 1'b0; dn_b[0] = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (mode0 !== 2'd0) begin
            failures++;
            $display("FAIL both_buttons: mode=%0d, required 0", mode0);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        up_b[0] = 1'b1;
        exp_q.push_back(1);
        exp_q.push_back(0);
        @(negedge clk);
        dn_b[0] = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (mode0 !== 2'd1 || ch0 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first: mode=%0d chg=%b, required 1/1", mode0, ch0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (mode0 !== 2'd0 || ch0 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second: mode=%0d chg=%b, required 0/1", mode0, ch0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ch0 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: chg=%b, required 0", ch0);
        end
        repeat (4) @(negedge clk);
        up_b[0] = 1'b0; dn_b[0] = 1'b0;
        repeat (15) @(negedge clk);
    endtask

    task automatic test_clear_en();
        exp_q.push_back(1);
        press(0, 1'b1, 10, 15);
        exp_q.push_back(2);
        press(0, 1'b1, 10, 15);
        checks++;
        if (mode0 !== 2'd2) begin
            failures++;
            $display("FAIL clear_setup: mode=%0d, required 2", mode0);
        end
        // clear spans the edge where the up step would land
        @(negedge clk);
        up_b[0] = 1'b1;
        exp_q.push_back(0);
        repeat (5) @(negedge clk);
        clr_b[0] = 1'b1;
        repeat (4) @(negedge clk);
        clr_b[0] = 1'b0;
        @(negedge clk);
        up_b[0] = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (mode0 !== 2'd0 || led0 !== 4'b0001) begin
            failures++;
            $display("FAIL clear_with_up: mode=%0d led=%b, required 0/0001", mode0, led0);
        end
        en_b[0] = 1'b0;
        press(0, 1'b1, 10, 15);
        en_b[0] = 1'b1;
        checks++;
        if (mode0 !== 2'd0) begin
            failures++;
            $display("FAIL en_low: mode=%0d, required 0", mode0);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        up_b[0] = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(1);
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (mode0 !== 2'd0) begin
            failures++;
            $display("FAIL rst_mid_early: mode=%0d, required 0", mode0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (mode0 !== 2'd1 || ch0 !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_held: mode=%0d chg=%b, required 1/1", mode0, ch0);
        end
        repeat (3) @(negedge clk);
        up_b[0] = 1'b0;
        repeat (15) @(negedge clk);
    endtask

`ifdef TEMP_MODE_AUTOREPEAT_EN
    task automatic test_autorepeat();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        exp_q.push_back(1);
        press(0, 1'b1, 50, 20);
        checks++;
        if (mode0 !== 2'd1) begin
            failures++;
            $display("FAIL autorepeat: mode=%0d, required 1", mode0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_up_wrap();
        test_glitch();
        test_saturate();
        test_both();
        test_back_to_back();
        test_clear_en();
        test_reset_mid();
`ifdef TEMP_MODE_AUTOREPEAT_EN
        test_autorepeat();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d expected pulses never seen, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
